// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the fetch (I) and load/store (D) ports; each grant runs a fixed 4-cycle sequence.
// Optional build macro SRAM_ARB_RR_EN selects round-robin on conflicts; default is fixed priority with D over I.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32  // four byte lanes, must stay 8 x 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [3:0]            d_be,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic                  sram_read,
   output logic [3:0]            sram_write,
   output logic [DATA_WIDTH-1:0] sram_DI,
   input  logic [DATA_WIDTH-1:0] sram_DO
);

   typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    owner_q, owner_d;   // 1 = D holds the grant
   logic                    rd_q, rd_d;         // in-flight command is a read
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    read_q, read_d;
   logic [3:0]              write_q, write_d;
   logic [DATA_WIDTH-1:0]   di_q, di_d;
   logic                    i_ack_q, i_ack_d;
   logic                    d_ack_q, d_ack_d;
   logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
   logic                    d_wins;

`ifdef SRAM_ARB_RR_EN
   // owner_q doubles as grant history: on a conflict D wins only if I was served last.
   assign d_wins = d_req & (~i_req | ~owner_q);
`else
   assign d_wins = d_req;
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      owner_d   = owner_q;
      rd_d      = rd_q;
      addr_d    = addr_q;
      read_d    = 1'b0;
      write_d   = 4'b0000;
      di_d      = di_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d = CMD;
               owner_d = d_wins;
               if (d_wins) begin
                  addr_d  = d_addr;
                  rd_d    = ~d_we;
                  read_d  = ~d_we;
                  write_d = d_we ? d_be : 4'b0000;
                  di_d    = d_we ? d_wdata : di_q;
               end else begin
                  addr_d  = i_addr;
                  rd_d    = 1'b1;
                  read_d  = 1'b1;
               end
            end
         end
         CMD:  state_d = RESP;
         RESP: begin
            state_d = DONE;
            if (owner_q) begin
               d_ack_d = 1'b1;
               if (rd_q) d_rdata_d = sram_DO;
            end else begin
               i_ack_d   = 1'b1;
               i_rdata_d = sram_DO;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         read_q    <= 1'b0;
         write_q   <= 4'b0000;
         di_q      <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         read_q    <= read_d;
         write_q   <= write_d;
         di_q      <= di_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign sram_addr  = addr_q;
   assign sram_read  = read_q;
   assign sram_write = write_q;
   assign sram_DI    = di_q;
   assign i_ack      = i_ack_q;
   assign d_ack      = d_ack_q;
   assign i_rdata    = i_rdata_q;
   assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM; expectations are hand-computed constants.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [13:0] i_addr, d_addr;
   logic [3:0]  d_be;
   logic [31:0] d_wdata;
   logic        i_ack, d_ack;
   logic [31:0] i_rdata, d_rdata;
   logic [13:0] sram_addr;
   logic        sram_read;
   logic [3:0]  sram_write;
   logic [31:0] sram_DI, sram_DO;

   logic [31:0] mem [0:16383];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
      .sram_DI(sram_DI), .sram_DO(sram_DO)
   );

   // SRAM model: registered read, byte-masked write; preloaded while reset is low.
   always @(posedge clk) begin
      if (!rst) begin
         mem[14'h0004] <= 32'h11223344;
         mem[14'h0008] <= 32'h00000055;
         mem[14'h0010] <= 32'h8C220004;
         mem[14'h0020] <= 32'hD0D0D0D0;
         mem[14'h0030] <= 32'h1A1A1A1A;
         mem[14'h0040] <= 32'hCAFEF00D;
      end else begin
         if (sram_read) sram_DO <= mem[sram_addr];
         for (int b = 0; b < 4; b++)
            if (sram_write[b]) mem[sram_addr][8*b +: 8] <= sram_DI[8*b +: 8];
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({i_ack, d_ack, i_rdata, d_rdata, sram_addr, sram_read, sram_write, sram_DI} !== 117'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got ack=%b%b sram_read=%b sram_write=%b sram_addr=%h, required all zero",
                  i_ack, d_ack, sram_read, sram_write, sram_addr);
      end
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({sram_read, sram_write} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_no_strobe[%0d]: got read=%b write=%b, required 0/0", k, sram_read, sram_write);
         end
      end
   endtask

   task automatic test_single_fetch();
      i_addr = 14'h0010;
      i_req  = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({sram_read, sram_write, sram_addr, i_ack} !== {1'b1, 4'b0, 14'h0010, 1'b0}) begin
         n_err++;
         $display("FAIL fetch_cmd: got read=%b write=%b addr=%h ack=%b, required 1/0/0010/0",
                  sram_read, sram_write, sram_addr, i_ack);
      end
      @(negedge clk);
      n_cmp++;
      if ({sram_read, i_ack} !== 2'b00) begin
         n_err++;
         $display("FAIL fetch_cmd_width: got read=%b ack=%b, required 0/0", sram_read, i_ack);
      end
      @(negedge clk);
      n_cmp++;
      if ({i_ack, d_ack, i_rdata} !== {1'b1, 1'b0, 32'h8C220004}) begin
         n_err++;
         $display("FAIL fetch_ack: got i_ack=%b d_ack=%b i_rdata=%h, required 1/0/8c220004", i_ack, d_ack, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (i_ack !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_ack_pulse: got i_ack=%b, required 0", i_ack);
      end
      @(negedge clk);
      n_cmp++;
      if (sram_read !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_no_second: got read=%b, required 0", sram_read);
      end
   endtask

   task automatic test_byte_store_load();
      d_we = 1'b1; d_be = 4'b0011; d_addr = 14'h0004; d_wdata = 32'hAABBCCDD;
      d_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({sram_read, sram_write, sram_addr, sram_DI} !== {1'b0, 4'b0011, 14'h0004, 32'hAABBCCDD}) begin
         n_err++;
         $display("FAIL store_cmd: got read=%b write=%b addr=%h DI=%h, required 0/0011/0004/aabbccdd",
                  sram_read, sram_write, sram_addr, sram_DI);
      end
      @(negedge clk);
      n_cmp++;
      if (sram_write !== 4'b0) begin
         n_err++;
         $display("FAIL store_strobe_width: got write=%b, required 0000", sram_write);
      end
      @(negedge clk);
      n_cmp++;
      if ({d_ack, i_ack, d_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL store_ack: got d_ack=%b i_ack=%b d_rdata=%h, required 1/0/00000000", d_ack, i_ack, d_rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem[14'h0004] !== 32'h1122CCDD) begin
         n_err++;
         $display("FAIL store_mem: got %h, required 1122ccdd", mem[14'h0004]);
      end
      d_we = 1'b0; d_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({sram_read, sram_write, sram_addr} !== {1'b1, 4'b0, 14'h0004}) begin
         n_err++;
         $display("FAIL load_cmd: got read=%b write=%b addr=%h, required 1/0000/0004", sram_read, sram_write, sram_addr);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({d_ack, d_rdata} !== {1'b1, 32'h1122CCDD}) begin
         n_err++;
         $display("FAIL load_ack: got d_ack=%b d_rdata=%h, required 1/1122ccdd", d_ack, d_rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_be_zero();
      d_we = 1'b1; d_be = 4'b0000; d_addr = 14'h0008; d_wdata = 32'hFFFFFFFF;
      d_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({sram_read, sram_write, sram_addr} !== {1'b0, 4'b0, 14'h0008}) begin
         n_err++;
         $display("FAIL be0_cmd: got read=%b write=%b addr=%h, required 0/0000/0008", sram_read, sram_write, sram_addr);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({d_ack, d_rdata} !== {1'b1, 32'h1122CCDD}) begin
         n_err++;
         $display("FAIL be0_ack: got d_ack=%b d_rdata=%h, required 1/1122ccdd", d_ack, d_rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem[14'h0008] !== 32'h00000055) begin
         n_err++;
         $display("FAIL be0_mem: got %h, required 00000055", mem[14'h0008]);
      end
   endtask

   task automatic test_conflict();
      logic exp_d;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      d_we = 1'b0; d_addr = 14'h0020; i_addr = 14'h0030;
      d_req = 1'b1; i_req = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
`ifdef SRAM_ARB_RR_EN
         exp_d = ((((k - 1) / 4) % 2) == 0);
`else
         exp_d = 1'b1;
`endif
         n_cmp++;
         if (k % 4 == 1) begin
            if ({sram_read, sram_addr} !== {1'b1, (exp_d ? 14'h0020 : 14'h0030)}) begin
               n_err++;
               $display("FAIL conflict_grant[%0d]: got read=%b addr=%h, required D=%b", k, sram_read, sram_addr, exp_d);
            end
         end else if (k % 4 == 3) begin
            if ({i_ack, d_ack} !== {~exp_d, exp_d} ||
                (exp_d ? d_rdata : i_rdata) !== (exp_d ? 32'hD0D0D0D0 : 32'h1A1A1A1A)) begin
               n_err++;
               $display("FAIL conflict_ack[%0d]: got i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h, required D=%b",
                        k, i_ack, d_ack, i_rdata, d_rdata, exp_d);
            end
         end else begin
            if ({i_ack, d_ack} !== 2'b00) begin
               n_err++;
               $display("FAIL conflict_quiet[%0d]: got i_ack=%b d_ack=%b, required 0/0", k, i_ack, d_ack);
            end
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      d_we = 1'b0; d_addr = 14'h0040; d_req = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({sram_read, sram_addr} !== {1'b1, 14'h0040}) begin
         n_err++;
         $display("FAIL rmid_cmd: got read=%b addr=%h, required 1/0040", sram_read, sram_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({sram_addr, sram_read, d_ack, d_rdata} !== {14'h0, 1'b0, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL rmid_async: got addr=%h read=%b d_ack=%b d_rdata=%h, required all zero",
                  sram_addr, sram_read, d_ack, d_rdata);
      end
      @(negedge clk);
      n_cmp++;
      if (d_ack !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_no_ack: got d_ack=%b, required 0", d_ack);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({sram_read, sram_addr} !== {1'b1, 14'h0040}) begin
         n_err++;
         $display("FAIL rmid_reissue: got read=%b addr=%h, required 1/0040", sram_read, sram_addr);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({d_ack, d_rdata} !== {1'b1, 32'hCAFEF00D}) begin
         n_err++;
         $display("FAIL rmid_ack: got d_ack=%b d_rdata=%h, required 1/cafef00d", d_ack, d_rdata);
      end
      d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_held_req();
      i_addr = 14'h0010; i_req = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1 || k == 5) begin
            n_cmp++;
            if ({sram_read, sram_addr} !== {1'b1, 14'h0010}) begin
               n_err++;
               $display("FAIL held_grant[%0d]: got read=%b addr=%h, required 1/0010", k, sram_read, sram_addr);
            end
         end else if (k == 3 || k == 7) begin
            n_cmp++;
            if ({i_ack, i_rdata} !== {1'b1, 32'h8C220004}) begin
               n_err++;
               $display("FAIL held_ack[%0d]: got i_ack=%b i_rdata=%h, required 1/8c220004", k, i_ack, i_rdata);
            end
         end else if (k >= 9) begin
            n_cmp++;
            if ({sram_read, i_ack} !== 2'b00) begin
               n_err++;
               $display("FAIL held_drop[%0d]: got read=%b i_ack=%b, required 0/0", k, sram_read, i_ack);
            end
         end
         if (k == 8) i_req = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0;
      test_reset();
      test_single_fetch();
      test_byte_store_load();
      test_store_be_zero();
      test_conflict();
      test_reset_mid();
      test_held_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

endmodule
